// File: rtl/map_gen_pkg.sv
// Shared types and helpers for the parametrised map generator.
// The state enum, the default tap mask and seed, and the LFSR feedback function.
package map_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        LATCH,
        DONE
    } map_state_t;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h00;

    // Returns the bit shifted into the LSB on each step: XNOR of the tapped state bits.
    // Callers zero-extend narrower registers; the extra zero bits leave the parity unchanged.
    function automatic logic lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        return ~^(state & taps);
    endfunction

endpackage

// File: rtl/map_gen_lfsr.sv
// Fibonacci XNOR LFSR of generic width.
// Load has priority over step; hold freezes the register even when step is asserted.
module map_gen_lfsr
    import map_gen_pkg::*;
#(
    parameter int             W    = 8,
    parameter logic [W-1:0]   TAPS = W'(DEFAULT_TAPS),
    parameter logic [W-1:0]   SEED = W'(DEFAULT_SEED)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         hold,
    output logic [W-1:0] sr
);

    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= SEED;
        end else if (step && !hold) begin
            sr <= {sr[W-2:0], lfsr_next(32'(sr), 32'(TAPS))};
        end
    end

endmodule

// File: rtl/map_gen_param.sv
// Parametrised map generator: counts N[N_W-1:1] LFSR steps, then latches dp = {sr, N[0]}.
// Optional feature: define MAP_GEN_RETRIGGER_EN to let a start edge restart an active run.
module map_gen_param
    import map_gen_pkg::*;
#(
    parameter int               N_W  = 9,
    parameter logic [N_W-2:0]   TAPS = (N_W-1)'(DEFAULT_TAPS),
    parameter logic [N_W-2:0]   SEED = (N_W-1)'(DEFAULT_SEED)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    input  logic [N_W-1:0]   N,
    output logic [N_W-1:0]   dp,
    output logic             done,
    output logic             busy,
    output logic [N_W-2:0]   counter,
    output logic [N_W-2:0]   sr
);

    map_state_t state;
    map_state_t next_state;
    logic       sb0;
    logic       sb1;
    logic       start_edge;
    logic       retrigger;
    logic       load;
    logic       step;
    logic       latch;

    assign start_edge = sb0 & ~sb1;

`ifdef MAP_GEN_RETRIGGER_EN
    assign retrigger = start_edge;
`else
    assign retrigger = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A restart edge outranks hold; otherwise hold freezes RUN entirely.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    next_state = INIT;
                end
            end
            INIT: begin
                load       = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                if (retrigger) begin
                    next_state = INIT;
                end else if (counter == '0) begin
                    if (!hold) begin
                        next_state = LATCH;
                    end
                end else begin
                    step = 1'b1;
                end
            end
            LATCH: begin
                if (retrigger) begin
                    next_state = INIT;
                end else begin
                    latch      = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = retrigger ? INIT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb0     <= 1'b0;
            sb1     <= 1'b0;
            busy    <= 1'b0;
            counter <= '0;
            dp      <= '0;
            done    <= 1'b0;
        end else begin
            sb0  <= start;
            sb1  <= sb0;
            busy <= (next_state == INIT) || (next_state == RUN) || (next_state == LATCH);
            if (load) begin
                counter <= N[N_W-1:1];
                done    <= 1'b0;
            end else if (step && !hold) begin
                counter <= counter - (N_W-1)'(1);
            end
            // done rises together with dp so a consumer sees both on the same cycle.
            if (latch) begin
                dp   <= {sr, N[0]};
                done <= 1'b1;
            end
        end
    end

    map_gen_lfsr #(
        .W    (N_W-1),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .step  (step),
        .hold  (hold),
        .sr    (sr)
    );

endmodule

// File: tb/tb_map_gen_param.sv
// Self-checking bench for map_gen_param (default build, N_W=9, TAPS=8'hB8, SEED=0).
// Expected values come from an arithmetic model of the shift sequence and the stated latency.
module tb_map_gen_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hold  = 1'b0;
    logic [8:0] N     = '0;
    logic [8:0] dp;
    logic       done;
    logic       busy;
    logic [7:0] counter;
    logic [7:0] sr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    map_gen_param dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .hold    (hold),
        .N       (N),
        .dp      (dp),
        .done    (done),
        .busy    (busy),
        .counter (counter),
        .sr      (sr)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Register value after n>>1 steps: each step doubles and adds 1 when the tapped bits have even weight.
    function automatic int modelSr(input int n);
        int s = 0;
        for (int i = 0; i < n / 2; i++) begin
            int fb = ($countones(s & 'hB8) % 2 == 0) ? 1 : 0;
            s = (s * 2 + fb) % 256;
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One run: pulse start, optionally hold RUN for holdLen cycles, optionally poke start mid-run.
    task automatic applyStimulus(input int n, input int holdLen, input int pokeAt, input string tag);
        int c      = n / 2;
        int cycles = 0;
        int expSr  = modelSr(n);
        @(posedge clock); #1;
        N     = 9'(n);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (!(cycles > 2 && done === 1'b1) && cycles < 400) begin
            @(posedge clock); #1;
            cycles++;
            if (cycles == 1) checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            if (cycles == 2) begin
                checkOutput({tag, "_cnt_load"}, 32'(counter), 32'(c));
                checkOutput({tag, "_done_clr"}, 32'(done), 32'd0);
                if (holdLen > 0) hold = 1'b1;
            end
            if (holdLen > 0 && cycles == 2 + holdLen) begin
                checkOutput({tag, "_cnt_frozen"}, 32'(counter), 32'(c));
                hold = 1'b0;
            end
            if (pokeAt > 0 && cycles == pokeAt) start = 1'b1;
            if (pokeAt > 0 && cycles == pokeAt + 1) start = 1'b0;
        end
        hold  = 1'b0;
        start = 1'b0;
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(4 + c + holdLen));
        checkOutput({tag, "_dp"}, 32'(dp), 32'(expSr * 2 + n % 2));
        checkOutput({tag, "_sr"}, 32'(sr), 32'(expSr));
        checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clock); #1;
        checkOutput({tag, "_done_sticky"}, 32'(done), 32'd1);
        repeat (2) @(posedge clock);
    endtask

    initial begin
        int waitCycles;
        int runs;
        logic prevBusy;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_dp", 32'(dp), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_counter", 32'(counter), 32'd0);
        checkOutput("rst_sr", 32'(sr), 32'd0);
        reset = 1'b0;

        applyStimulus(0, 0, 0, "t1_n0");
        checkOutput("t1_dp_const", 32'(dp), 32'h000);
        applyStimulus(2, 0, 0, "t2_n2");
        checkOutput("t2_sr_const", 32'(sr), 32'h01);
        applyStimulus(5, 0, 0, "t3_n5");
        checkOutput("t3_dp_const", 32'(dp), 32'h007);
        applyStimulus(5, 3, 0, "t4_hold");
        applyStimulus(41, 0, 5, "t5_ignore");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(int'($urandom_range(0, 80)), int'($urandom_range(0, 3)), 0, "rand");
        end

        // Reset in the middle of a long run.
        @(posedge clock); #1;
        N     = 9'd200;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        waitCycles = 0;
        while (counter !== 8'd40 && waitCycles < 300) begin
            @(posedge clock); #1;
            waitCycles++;
        end
        checkOutput("t6_reach40", 32'(counter), 32'd40);
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("t6_dp", 32'(dp), 32'd0);
        checkOutput("t6_done", 32'(done), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_counter", 32'(counter), 32'd0);
        checkOutput("t6_sr", 32'(sr), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Start held high for 20 cycles must trigger exactly one run.
        N        = 9'd5;
        start    = 1'b1;
        runs     = 0;
        prevBusy = busy;
        for (int i = 0; i < 35; i++) begin
            @(posedge clock); #1;
            if (busy && !prevBusy) runs++;
            prevBusy = busy;
            if (i == 19) start = 1'b0;
        end
        checkOutput("t6_single_run", 32'(runs), 32'd1);
        checkOutput("t6_held_dp", 32'(dp), 32'h007);
        checkOutput("t6_held_done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
